// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared helpers for the fifo_flex buffer.
// Holds the pointer-width function and the parameter-legality predicates
// that the top level evaluates at elaboration time.
package fifo_flex_pkg;

    // Address bits needed to index a Depth-entry memory (at least 1).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Depth must be a power of two and hold at least two entries.
    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    // almostFull threshold must lie in 1..Depth.
    function automatic bit af_thr_legal(input int depth, input int thr);
        return (thr >= 1) && (thr <= depth);
    endfunction

    // almostEmpty threshold must lie in 0..Depth-1.
    function automatic bit ae_thr_legal(input int depth, input int thr);
        return (thr >= 0) && (thr <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// fifo_flex_mem: Depth x DataWidth register array with one write port and
// one read port. With FIFO_FLEX_FWFT_EN defined the read port is
// asynchronous (head entry always visible); otherwise it is registered and
// only updates on a read enable.
module fifo_flex_mem
    import fifo_flex_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Depth     = 16,
    parameter int AddrWidth = ptr_width(Depth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [DataWidth-1:0] rd_data_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef FIFO_FLEX_FWFT_EN
    // Reset and read enable are not needed by the asynchronous read port.
    logic unused_ok;
    assign unused_ok = &{1'b0, rst, rd_en_i};

    assign rd_data_o = mem_q[rd_addr_i];
`else
    logic [DataWidth-1:0] rd_data_q;

    // Registered read port: captures the head entry on an accepted read and
    // holds it otherwise; output is zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
`endif

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with fill level, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_FLEX_FWFT_EN selects first-word-fall-through reads;
// without it readData is registered with one cycle of read latency.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int Depth          = 16,
    parameter int AlmostFullThr  = Depth - 2,
    parameter int AlmostEmptyThr = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   writeEn,
    input  logic [DataWidth-1:0]   writeData,
    input  logic                   readEn,
    input  logic                   clearErr,
    output logic [DataWidth-1:0]   readData,
    output logic                   full,
    output logic                   empty,
    output logic                   almostFull,
    output logic                   almostEmpty,
    output logic [$clog2(Depth):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PtrWidth = ptr_width(Depth);
    localparam int LvlWidth = PtrWidth + 1;
    localparam logic [LvlWidth-1:0] DepthLvl = LvlWidth'(Depth);
    localparam logic [LvlWidth-1:0] AfThr    = LvlWidth'(AlmostFullThr);
    localparam logic [LvlWidth-1:0] AeThr    = LvlWidth'(AlmostEmptyThr);

    if (!depth_legal(Depth)) begin : g_bad_depth
        $error("fifo_flex: Depth must be a power of two and at least 2");
    end
    if (!af_thr_legal(Depth, AlmostFullThr)) begin : g_bad_af
        $error("fifo_flex: AlmostFullThr must be in 1..Depth");
    end
    if (!ae_thr_legal(Depth, AlmostEmptyThr)) begin : g_bad_ae
        $error("fifo_flex: AlmostEmptyThr must be in 0..Depth-1");
    end

    logic [PtrWidth:0] wrPtr_q, wrPtr_d;
    logic [PtrWidth:0] rdPtr_q, rdPtr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_accept, rd_accept;
    logic [LvlWidth-1:0]  level_w;
    logic [DataWidth-1:0] mem_rd_data;

    // Status decodes purely from the registered pointers; the wrap bit keeps
    // full (difference == Depth) distinct from empty (difference == 0).
    assign level_w     = wrPtr_q - rdPtr_q;
    assign full        = (level_w == DepthLvl);
    assign empty       = (level_w == '0);
    assign almostFull  = (level_w >= AfThr);
    assign almostEmpty = (level_w <= AeThr);
    assign level       = level_w;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    assign wr_accept = writeEn && !full;
    assign rd_accept = readEn && !empty;

    // Next-state for pointers and sticky error flags; an error event in the
    // same cycle as clearErr wins over the clear.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        overflow_d  = clearErr ? 1'b0 : overflow_q;
        underflow_d = clearErr ? 1'b0 : underflow_q;
        if (wr_accept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (rd_accept) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (writeEn && full) begin
            overflow_d = 1'b1;
        end
        if (readEn && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_flex_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrWidth (PtrWidth)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wrPtr_q[PtrWidth-1:0]),
        .wr_data_i (writeData),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rdPtr_q[PtrWidth-1:0]),
        .rd_data_o (mem_rd_data)
    );

`ifdef FIFO_FLEX_FWFT_EN
    // Head entry is shown directly; forced to zero while nothing is stored.
    assign readData = empty ? '0 : mem_rd_data;
`else
    assign readData = mem_rd_data;
`endif

endmodule
